// File: rtl/submsg_reg_writer_pkg.sv
// submsg_reg_writer_pkg: chain-protocol cmd codes and submessage FSM state encodings
package submsg_reg_writer_pkg;
    localparam logic [7:0] CMD_NOP   = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_COUNT   = 3'd2,
        ST_DATA    = 3'd3,
        ST_DISCARD = 3'd4
    } state_e;
endpackage

// File: rtl/submsg_word_asm.sv
// submsg_word_asm: little-endian byte-to-word assembler with byte counter and word-complete flag
// Ports: clk/rst; clr_i zeroes the byte counter; en_i accepts byte_i;
//        word_o is the word including the current byte; done_o flags the 4th byte of a word.
module submsg_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        done_o
);
    logic [31:0] sh_q, sh_d;
    logic [1:0]  bcnt_q, bcnt_d;
    always_comb begin
        word_o = {byte_i, sh_q[31:8]};
        done_o = en_i && bcnt_q == 2'd3;
        sh_d   = en_i ? word_o : sh_q;
        bcnt_d = clr_i ? 2'd0 : en_i ? bcnt_q + 2'd1 : bcnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            bcnt_q <= '0;
        end else begin
            sh_q   <= sh_d;
            bcnt_q <= bcnt_d;
        end
    end
endmodule

// File: rtl/submsg_reg_writer.sv
// submsg_reg_writer: parses WRITE_REGS/NOP submessages into register write strobes
// Ports: clk/rst; rxd/rxdv/rxlast byte stream in (no backpressure);
//        reg_we/reg_addr/reg_wdata write port; msg_done/msg_err end pulses; msg_cnt/err_cnt saturating counts.
module submsg_reg_writer
    import submsg_reg_writer_pkg::*;
#(
    parameter int MAX_WORDS = 64,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rxd,
    input  logic              rxdv,
    input  logic              rxlast,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [31:0]       reg_wdata,
    output logic              msg_done,
    output logic              msg_err,
    output logic [15:0]       msg_cnt,
    output logic [15:0]       err_cnt
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, reg_addr_q, reg_addr_d;
    logic [7:0]        cnt_q, cnt_d, widx_q, widx_d;
    logic [31:0]       reg_wdata_q, reg_wdata_d, word;
    logic [15:0]       msg_cnt_q, msg_cnt_d, err_cnt_q, err_cnt_d;
    logic              reg_we_q, we_d, done_q, done_d, err_q, err_d;
    logic              in_data, word_done, last_word, too_big;

    assign in_data   = state_q == ST_DATA;
    assign too_big   = 32'(rxd) > MAX_WORDS;
    assign last_word = word_done && widx_q == cnt_q - 8'd1;

    submsg_word_asm u_asm (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (!in_data),
        .en_i   (in_data && rxdv),
        .byte_i (rxd),
        .word_o (word),
        .done_o (word_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Any accepted rxlast returns to IDLE; only the path decides done vs error.
    always_comb begin
        state_d = state_q;
        if (rxdv) begin
            case (state_q)
                ST_IDLE:  state_d = rxlast ? ST_IDLE : rxd == CMD_WRITE ? ST_ADDR : ST_DISCARD;
                ST_ADDR:  state_d = rxlast ? ST_IDLE : ST_COUNT;
                ST_COUNT: state_d = rxlast ? ST_IDLE : (too_big || rxd == 8'd0) ? ST_DISCARD : ST_DATA;
                ST_DATA:  state_d = rxlast ? ST_IDLE : last_word ? ST_DISCARD : ST_DATA;
                default:  state_d = rxlast ? ST_IDLE : ST_DISCARD;
            endcase
        end
    end

    // Every message end is exactly one of done or err, so err is the complement of done.
    always_comb begin
        done_d = rxdv && rxlast && ((state_q == ST_IDLE && rxd == CMD_NOP) ||
                                    (state_q == ST_COUNT && rxd == 8'd0) ||
                                    (in_data && last_word));
        err_d  = rxdv && rxlast && !done_d;
        we_d   = in_data && word_done;
    end

    always_comb begin
        addr_d      = (state_q == ST_ADDR && rxdv) ? ADDR_W'(rxd) : addr_q;
        cnt_d       = (state_q == ST_COUNT && rxdv) ? rxd : cnt_q;
        widx_d      = !in_data ? 8'd0 : widx_q + 8'(word_done);
        reg_addr_d  = we_d ? addr_q + ADDR_W'(widx_q) : reg_addr_q;
        reg_wdata_d = we_d ? word : reg_wdata_q;
        msg_cnt_d   = (done_d && msg_cnt_q != 16'hFFFF) ? msg_cnt_q + 16'd1 : msg_cnt_q;
        err_cnt_d   = (err_d && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            cnt_q       <= '0;
            widx_q      <= '0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            msg_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            widx_q      <= widx_d;
            reg_we_q    <= we_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            msg_cnt_q   <= msg_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign reg_we    = reg_we_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign msg_done  = done_q;
    assign msg_err   = err_q;
    assign msg_cnt   = msg_cnt_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_submsg_reg_writer.sv
// tb_submsg_reg_writer: table-driven directed bench for submsg_reg_writer
module tb_submsg_reg_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rxd = 8'h00;
    logic        rxdv = 1'b0;
    logic        rxlast = 1'b0;
    logic        reg_we, msg_done, msg_err;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [15:0] msg_cnt, err_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic        v;
        logic [7:0]  b;
        logic        l;
        logic        we;
        logic [7:0]  a;
        logic [31:0] d;
        logic        dn;
        logic        er;
        logic [15:0] mc;
        logic [15:0] ec;
    } vec_t;

    vec_t tv[$];

    submsg_reg_writer #(.MAX_WORDS(64), .ADDR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rxdv      (rxdv),
        .rxlast    (rxlast),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .msg_done  (msg_done),
        .msg_err   (msg_err),
        .msg_cnt   (msg_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic v, logic [7:0] b, logic l, logic we, logic [7:0] a,
                                logic [31:0] d, logic dn, logic er, logic [15:0] mc, logic [15:0] ec);
        vec_t t;
        t = '{v:v, b:b, l:l, we:we, a:a, d:d, dn:dn, er:er, mc:mc, ec:ec};
        return t;
    endfunction

    function automatic vec_t by(logic [7:0] b, logic [15:0] mc, logic [15:0] ec);
        return mk(1'b1, b, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, mc, ec);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle (byte or idle gap with junk rxd/rxlast), then check the outputs it produced.
    task automatic step(input vec_t t, input string tag);
        rxdv   = t.v;
        rxd    = t.v ? t.b : 8'h5A;
        rxlast = t.v ? t.l : 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".we"}, 32'(reg_we), 32'(t.we));
        if (t.we) begin
            chk({tag, ".addr"}, 32'(reg_addr), 32'(t.a));
            chk({tag, ".wdata"}, reg_wdata, t.d);
        end
        chk({tag, ".done"}, 32'(msg_done), 32'(t.dn));
        chk({tag, ".err"}, 32'(msg_err), 32'(t.er));
        chk({tag, ".mcnt"}, 32'(msg_cnt), 32'(t.mc));
        chk({tag, ".ecnt"}, 32'(err_cnt), 32'(t.ec));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".we"}, 32'(reg_we), 32'h0);
        chk({tag, ".addr"}, 32'(reg_addr), 32'h0);
        chk({tag, ".wdata"}, reg_wdata, 32'h0);
        chk({tag, ".done"}, 32'(msg_done), 32'h0);
        chk({tag, ".err"}, 32'(msg_err), 32'h0);
        chk({tag, ".mcnt"}, 32'(msg_cnt), 32'h0);
        chk({tag, ".ecnt"}, 32'(err_cnt), 32'h0);
    endtask

    initial begin
        logic [31:0] w;
        // Two-word write at 0x10
        tv.push_back(by(8'h01, 0, 0)); tv.push_back(by(8'h10, 0, 0)); tv.push_back(by(8'h02, 0, 0));
        tv.push_back(by(8'h78, 0, 0)); tv.push_back(by(8'h56, 0, 0)); tv.push_back(by(8'h34, 0, 0));
        tv.push_back(mk(1, 8'h12, 0, 1, 8'h10, 32'h12345678, 0, 0, 0, 0));
        tv.push_back(by(8'hEF, 0, 0)); tv.push_back(by(8'hBE, 0, 0)); tv.push_back(by(8'hAD, 0, 0));
        tv.push_back(mk(1, 8'hDE, 1, 1, 8'h11, 32'hDEADBEEF, 1, 0, 1, 0));
        // Address wrap 0xFF -> 0x00
        tv.push_back(by(8'h01, 1, 0)); tv.push_back(by(8'hFF, 1, 0)); tv.push_back(by(8'h02, 1, 0));
        tv.push_back(by(8'h01, 1, 0)); tv.push_back(by(8'h00, 1, 0)); tv.push_back(by(8'h00, 1, 0));
        tv.push_back(mk(1, 8'h00, 0, 1, 8'hFF, 32'h00000001, 0, 0, 1, 0));
        tv.push_back(by(8'h02, 1, 0)); tv.push_back(by(8'h00, 1, 0)); tv.push_back(by(8'h00, 1, 0));
        tv.push_back(mk(1, 8'h00, 1, 1, 8'h00, 32'h00000002, 1, 0, 2, 0));
        // Short message: N=3, rxlast on 6th data byte
        tv.push_back(by(8'h01, 2, 0)); tv.push_back(by(8'h20, 2, 0)); tv.push_back(by(8'h03, 2, 0));
        tv.push_back(by(8'h11, 2, 0)); tv.push_back(by(8'h22, 2, 0)); tv.push_back(by(8'h33, 2, 0));
        tv.push_back(mk(1, 8'h44, 0, 1, 8'h20, 32'h44332211, 0, 0, 2, 0));
        tv.push_back(by(8'h55, 2, 0));
        tv.push_back(mk(1, 8'h66, 1, 0, 0, 0, 0, 1, 2, 1));
        // Bad cmd then back-to-back NOP
        tv.push_back(by(8'h7E, 2, 1)); tv.push_back(by(8'h00, 2, 1)); tv.push_back(by(8'h00, 2, 1));
        tv.push_back(mk(1, 8'h00, 1, 0, 0, 0, 0, 1, 2, 2));
        tv.push_back(mk(1, 8'h00, 1, 0, 0, 0, 1, 0, 3, 2));
        // N=65 > MAX_WORDS -> discard
        tv.push_back(by(8'h01, 3, 2)); tv.push_back(by(8'h00, 3, 2)); tv.push_back(by(8'h41, 3, 2));
        tv.push_back(by(8'hAA, 3, 2)); tv.push_back(by(8'hBB, 3, 2)); tv.push_back(by(8'hCC, 3, 2));
        tv.push_back(mk(1, 8'hDD, 1, 0, 0, 0, 0, 1, 3, 3));
        // N=0 with rxlast is done
        tv.push_back(by(8'h01, 3, 3)); tv.push_back(by(8'h05, 3, 3));
        tv.push_back(mk(1, 8'h00, 1, 0, 0, 0, 1, 0, 4, 3));
        // rxlast in ADDR, and WRITE cmd with rxlast in IDLE
        tv.push_back(by(8'h01, 4, 3));
        tv.push_back(mk(1, 8'h30, 1, 0, 0, 0, 0, 1, 4, 4));
        tv.push_back(mk(1, 8'h01, 1, 0, 0, 0, 0, 1, 4, 5));
        // N=0 without rxlast -> discard
        tv.push_back(by(8'h01, 4, 5)); tv.push_back(by(8'h05, 4, 5)); tv.push_back(by(8'h00, 4, 5));
        tv.push_back(mk(1, 8'h99, 1, 0, 0, 0, 0, 1, 4, 6));
        // Data ends without rxlast -> discard, word stays written
        tv.push_back(by(8'h01, 4, 6)); tv.push_back(by(8'h40, 4, 6)); tv.push_back(by(8'h01, 4, 6));
        tv.push_back(by(8'h01, 4, 6)); tv.push_back(by(8'h02, 4, 6)); tv.push_back(by(8'h03, 4, 6));
        tv.push_back(mk(1, 8'h04, 0, 1, 8'h40, 32'h04030201, 0, 0, 4, 6));
        tv.push_back(mk(1, 8'h05, 1, 0, 0, 0, 0, 1, 4, 7));

        #2;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (tv[i]) step(tv[i], $sformatf("v%0d", i));

        // Idle gaps mid-message hold all state
        step(by(8'h01, 4, 7), "gap0");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 7), "gap1");
        step(by(8'h60, 4, 7), "gap2");
        step(by(8'h01, 4, 7), "gap3");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 7), "gap4");
        step(by(8'h01, 4, 7), "gap5");
        step(by(8'h02, 4, 7), "gap6");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 7), "gap7");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 7), "gap8");
        step(by(8'h03, 4, 7), "gap9");
        step(mk(1, 8'h04, 1, 1, 8'h60, 32'h04030201, 1, 0, 5, 7), "gap10");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 7), "gap11");

        // N == MAX_WORDS is accepted: 64 full words from address 0x80
        step(by(8'h01, 5, 7), "max_c");
        step(by(8'h80, 5, 7), "max_a");
        step(by(8'h40, 5, 7), "max_n");
        for (int k = 0; k < 64; k++) begin
            w = 32'hA5C30000 | 32'(k);
            for (int j = 0; j < 3; j++) step(by(w[8*j +: 8], 5, 7), $sformatf("max%0d_%0d", k, j));
            step(mk(1, w[31:24], k == 63, 1, 8'h80 + 8'(k), w, k == 63, 0, k == 63 ? 16'd6 : 16'd5, 7),
                 $sformatf("max%0d_3", k));
        end

        // Reset mid-message abandons it silently
        step(by(8'h01, 6, 7), "rst_c");
        step(by(8'h10, 6, 7), "rst_a");
        step(by(8'h01, 6, 7), "rst_n");
        step(by(8'hAA, 6, 7), "rst_d0");
        step(by(8'hBB, 6, 7), "rst_d1");
        rxdv = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_zero("in_rst");
        @(negedge clk);
        chk_zero("in_rst2");
        rst = 1'b0;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst");
        step(mk(1, 8'h00, 1, 0, 0, 0, 1, 0, 1, 0), "post_nop");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "post_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/submsg_reg_writer.md
SUBMSG_REG_WRITER -- requirements
Module: submsg_reg_writer

Interface
REQ-001 Parameter MAX_WORDS, default 64: largest word count accepted per submessage.
REQ-002 Parameter ADDR_W, default 8: register address width.
REQ-003 clk  input  1  sole clock, the consumer-side (clk_100) domain of the outbound chain receiver.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rxd  input  8  submessage byte.
REQ-006 rxdv  input  1  byte valid; no backpressure exists.
REQ-007 rxlast  input  1  qualified by rxdv; marks the final byte of the submessage.
REQ-008 reg_we  output  1  one-cycle register write strobe.
REQ-009 reg_addr  output  ADDR_W  write address.
REQ-010 reg_wdata  output  32  write data.
REQ-011 msg_done  output  1  one-cycle pulse on a well-formed submessage end.
REQ-012 msg_err  output  1  one-cycle pulse on a malformed submessage end.
REQ-013 msg_cnt  output  16  count of msg_done pulses.
REQ-014 err_cnt  output  16  count of msg_err pulses.

Function
REQ-015 Submessage format: cmd byte, start address byte, count byte N, then N 32-bit words, each little-endian.
REQ-016 Only cmd 0x01 (WRITE_REGS) is valid; cmd 0x00 (NOP) consisting of one byte is also well-formed.
REQ-017 States: IDLE, ADDR, COUNT, DATA, DISCARD; the FSM advances only on cycles with rxdv high.
REQ-018 IDLE transitions on cmd byte:
- 0x01 -> ADDR
- 0x00 with rxlast -> done
- 0x00 without rxlast -> DISCARD
- any other value -> DISCARD
REQ-019 ADDR: latch start address -> COUNT.
REQ-020 COUNT: latch N.
- N > MAX_WORDS -> DISCARD.
- N == 0 with rxlast -> done.
- N == 0 without rxlast -> DISCARD.
- Otherwise -> DATA.
REQ-021 DATA: shift bytes into a 32-bit assembler, with byte 0 as the LSB, using a 2-bit byte counter and a word counter.
REQ-022 On the 4th byte of a word, reg_we is high the next cycle; reg_wdata is the assembled word; reg_addr is start_addr + word_index, modulo 2^ADDR_W (wraps).
REQ-023 Fixed latency of 1 clk from the 4th byte's rxdv to reg_we; back-to-back words produce reg_we at most once per 4 cycles.
REQ-024 Any rxlast received while in DATA leaves DATA:
- On the 4th byte of word N-1 -> done.
- Earlier -> error.
- Words already completed stay written; no rollback.
REQ-025 DATA ending after the last word without rxlast -> DISCARD.
REQ-026 DISCARD: ignore bytes until rxlast; then pulse msg_err and go to IDLE.
REQ-027 Any rxlast in ADDR or COUNT -> error -> IDLE.
REQ-028 "done" means: msg_done pulses the cycle after the final byte, msg_cnt increments, FSM returns to IDLE.
REQ-029 "error" means: msg_err pulses the cycle after the final byte, err_cnt increments, FSM returns to IDLE.
REQ-030 msg_done and msg_err are never high together.
REQ-031 Counters saturate at 16'hFFFF.
REQ-032 A byte with rxdv and rxlast arriving in IDLE counts as the cmd byte and ends the message immediately, per REQ-018.
REQ-033 rxd is don't-care while rxdv is low; idle gaps mid-message are permitted and hold all state.
REQ-034 A new submessage's first byte may arrive the cycle after the previous rxlast; no bytes are lost.

Reset
REQ-035 While rst is high, all of the following are 0 asynchronously: state (IDLE), assembler, byte/word counters, latched address and count, reg_we, reg_addr, reg_wdata, msg_done, msg_err, msg_cnt, err_cnt.
REQ-036 Reset mid-message abandons the message without a done or err pulse; the next byte after deassertion is treated as a cmd byte.

Structure
REQ-037 Cmd codes (0x00, 0x01) and the state encodings belong in the shared chain-protocol package used by the outbound chain modules.
REQ-038 The byte-to-word assembler, with its byte counter and word-complete flag, is one natural sub-module: submsg_word_asm.
REQ-039 All registers use the codebase's standard register/delay primitives.

Verification
REQ-040 Stimulus: 01 10 02 | 78 56 34 12 | EF BE AD DE, rxlast on the final byte.
- Required: reg_we at (0x10, 0x12345678) then (0x11, 0xDEADBEEF).
- Required: msg_done 1 cycle after the last byte; msg_cnt=1.
REQ-041 Stimulus: 01 FF 02 with two words.
- Required: writes to addresses 0xFF then 0x00 (wrap).
REQ-042 Stimulus: 01 20 03 with only 6 data bytes, rxlast on the 6th.
- Required: one write to 0x20, then msg_err; err_cnt=1; msg_cnt unchanged.
REQ-043 Stimulus: 7E 00 00 00 with rxlast, immediately followed by 00 with rxlast.
- Required: first message gives msg_err and no reg_we.
- Required: second message gives msg_done.
REQ-044 Stimulus: 01 00 41, with MAX_WORDS=64, followed by data.
- Required: DISCARD, no reg_we, msg_err on rxlast.
REQ-045 Stimulus: assert rst after 2 data bytes of a valid message, then send a clean NOP.
- Required: all outputs read 0 during reset; no err/done for the aborted message; NOP produces msg_done.
